// File: rtl/sw_input_port_pkg.sv
// Shared constants for the switch input peripheral: default base address,
// byte offsets of its four registers and the register selector type.
package sw_input_port_pkg;

  localparam logic [31:0] SWIN_ADRS_BASE = 32'h0000_7ff4;

  localparam logic [31:0] SWIN_STATE = 32'h0;
  localparam logic [31:0] SWIN_RISE  = 32'h4;
  localparam logic [31:0] SWIN_FALL  = 32'h8;
  localparam logic [31:0] SWIN_MASK  = 32'hc;

  typedef enum logic [1:0] {
    SWIN_REG_STATE = 2'd0,
    SWIN_REG_RISE  = 2'd1,
    SWIN_REG_FALL  = 2'd2,
    SWIN_REG_MASK  = 2'd3
  } swin_reg_e;

endpackage

// File: rtl/sw_input_port_debounce_bit.sv
// One switch input: two-flop synchroniser, stability counter and debounced
// level, with single-cycle pulses on the edge where the level toggles.
module sw_input_port_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise_pulse,
  output logic o_fall_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_done;

  // The level is accepted on the edge the count would reach DEBOUNCE_CYCLES.
  assign w_done = (r_sync != r_stable) && (r_cnt == CNT_LAST);

  always_comb begin
    w_cnt_next = r_cnt + 1'b1;
    if ((r_sync == r_stable) || w_done) begin
      w_cnt_next = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta   <= i_raw;
      r_sync   <= r_meta;
      r_cnt    <= w_cnt_next;
      if (w_done) begin
        r_stable <= ~r_stable;
      end
    end
  end

  assign o_level      = r_stable;
  assign o_rise_pulse = w_done & ~r_stable;
  assign o_fall_pulse = w_done &  r_stable;

endmodule

// File: rtl/sw_input_port.sv
// Memory-mapped switch input port: debounced levels, sticky read-to-clear
// edge flags, a writable interrupt mask and a level interrupt request.
module sw_input_port
  import sw_input_port_pkg::*;
#(
  parameter int          N_IN            = 10,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] ADRS_BASE       = SWIN_ADRS_BASE
) (
  input  logic            clk_cpu,
  input  logic            reset,
  input  logic [N_IN-1:0] sw_in,
  input  logic            bus_en,
  input  logic            bus_we,
  input  logic [31:0]     bus_adrs,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  output logic            bus_ack,
  output logic            irq
);

  logic [N_IN-1:0] w_level;
  logic [N_IN-1:0] w_rise_pulse;
  logic [N_IN-1:0] w_fall_pulse;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_bit
      sw_input_port_debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .i_clk        (clk_cpu),
        .i_reset      (reset),
        .i_raw        (sw_in[gi]),
        .o_level      (w_level[gi]),
        .o_rise_pulse (w_rise_pulse[gi]),
        .o_fall_pulse (w_fall_pulse[gi])
      );
    end
  endgenerate

  logic [N_IN-1:0] r_rise, r_fall, r_mask;
  logic [N_IN-1:0] w_rise_next, w_fall_next, w_mask_next;
  logic [31:0]     r_rdata, w_rdata_next, w_rd_val;
  logic [31:0]     w_offset;
  logic            r_ack, r_irq;
  logic            w_hit, w_rd_hit, w_wr_hit;
  logic            w_unused;
  swin_reg_e       w_reg;

  // The base is only word aligned, so registers are decoded from the offset.
  assign w_offset = bus_adrs - ADRS_BASE;
  assign w_reg    = swin_reg_e'(w_offset[3:2]);
  assign w_hit    = bus_en && (w_offset[31:4] == 28'd0);
  assign w_rd_hit = w_hit && !bus_we;
  assign w_wr_hit = w_hit &&  bus_we;
  assign w_unused = ^{w_offset[1:0], bus_wdata};

  always_comb begin
    w_rd_val = '0;
    case (w_reg)
      SWIN_REG_STATE: w_rd_val[N_IN-1:0] = w_level;
      SWIN_REG_RISE:  w_rd_val[N_IN-1:0] = r_rise;
      SWIN_REG_FALL:  w_rd_val[N_IN-1:0] = r_fall;
      SWIN_REG_MASK:  w_rd_val[N_IN-1:0] = r_mask;
      default:        w_rd_val = '0;
    endcase
  end

  always_comb begin
    w_rise_next  = r_rise | w_rise_pulse;
    w_fall_next  = r_fall | w_fall_pulse;
    w_mask_next  = r_mask;
    w_rdata_next = r_rdata;
    if (w_rd_hit) begin
      w_rdata_next = w_rd_val;
      // A new edge arriving on the clearing edge survives the clear.
      if (w_reg == SWIN_REG_RISE) w_rise_next = w_rise_pulse;
      if (w_reg == SWIN_REG_FALL) w_fall_next = w_fall_pulse;
    end
    if (w_wr_hit && (w_reg == SWIN_REG_MASK)) begin
      w_mask_next = bus_wdata[N_IN-1:0];
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      r_rise  <= '0;
      r_fall  <= '0;
      r_mask  <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
      r_mask  <= w_mask_next;
      r_rdata <= w_rdata_next;
      r_ack   <= w_hit;
      r_irq   <= |((r_rise | r_fall) & r_mask);
    end
  end

  assign bus_rdata = r_rdata;
  assign bus_ack   = r_ack;
  assign irq       = r_irq;

endmodule

// File: tb/tb_sw_input_port.sv
// Directed bench for sw_input_port: bus reads/writes, debounce latency,
// glitch rejection, read-to-clear races, irq timing, decode misses and reset.
module tb_sw_input_port;
  import sw_input_port_pkg::*;

  localparam logic [31:0] BASE = SWIN_ADRS_BASE;

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic [9:0]  sw_in;
  logic        bus_en;
  logic        bus_we;
  logic [31:0] bus_adrs;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_cpu = ~clk_cpu;

  sw_input_port #(
    .N_IN            (10),
    .DEBOUNCE_CYCLES (16),
    .ADRS_BASE       (BASE)
  ) dut (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .sw_in     (sw_in),
    .bus_en    (bus_en),
    .bus_we    (bus_we),
    .bus_adrs  (bus_adrs),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .irq       (irq)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_cpu);
      #1;
    end
  endtask

  // One bus cycle: drive, let the edge sample it, return what the DUT shows.
  task automatic bus_access(input logic we, input logic [31:0] adrs, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic ack);
    bus_en    = 1'b1;
    bus_we    = we;
    bus_adrs  = adrs;
    bus_wdata = wdata;
    @(posedge clk_cpu);
    #1;
    bus_en = 1'b0;
    bus_we = 1'b0;
    rdata  = bus_rdata;
    ack    = bus_ack;
    $display("%s adrs=0x%08h wdata=0x%08h rdata=0x%08h ack=%0b irq=%0b",
             we ? "WR" : "RD", adrs, wdata, rdata, ack, irq);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] ofs, input logic [31:0] exp);
    logic [31:0] d;
    logic        a;
    bus_access(1'b0, BASE + ofs, 32'h0, d, a);
    check_value({tag, "_ack"}, {31'd0, a}, 32'd1);
    check_value(tag, d, exp);
  endtask

  task automatic wr_check(input string tag, input logic [31:0] ofs, input logic [31:0] data);
    logic [31:0] d;
    logic        a;
    bus_access(1'b1, BASE + ofs, data, d, a);
    check_value({tag, "_ack"}, {31'd0, a}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic        a;
    reset = 1'b1; sw_in = '0; bus_en = 1'b0; bus_we = 1'b0;
    bus_adrs = '0; bus_wdata = '0;
    tick(2);
    check_value("rst_rdata", bus_rdata, 32'h0);
    check_value("rst_ack", {31'd0, bus_ack}, 32'd0);
    check_value("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;

    // Idle reads, back to back, then the ack must drop.
    rd_check("idle_state", SWIN_STATE, 32'h0);
    rd_check("idle_rise",  SWIN_RISE,  32'h0);
    rd_check("idle_fall",  SWIN_FALL,  32'h0);
    rd_check("idle_mask",  SWIN_MASK,  32'h0);
    tick(1);
    check_value("ack_drop", {31'd0, bus_ack}, 32'd0);
    check_value("idle_irq", {31'd0, irq}, 32'd0);

    // sw_in[3] step: STATE updates on edge 18, visible on a read at edge 19.
    sw_in = 10'h008;
    tick(17);
    rd_check("step_state_e18", SWIN_STATE, 32'h0);
    rd_check("step_state_e19", SWIN_STATE, 32'h8);
    rd_check("step_rise",      SWIN_RISE,  32'h8);
    rd_check("step_rise_clr",  SWIN_RISE,  32'h0);
    check_value("step_irq_masked", {31'd0, irq}, 32'd0);
    sw_in = 10'h000;
    tick(25);
    rd_check("step_fall",     SWIN_FALL, 32'h8);
    rd_check("step_fall_clr", SWIN_FALL, 32'h0);
    rd_check("step_rise_none", SWIN_RISE, 32'h0);

    // 10-cycle glitch on sw_in[0] is rejected.
    sw_in = 10'h001;
    tick(10);
    sw_in = 10'h000;
    tick(30);
    rd_check("glitch_state", SWIN_STATE, 32'h0);
    rd_check("glitch_rise",  SWIN_RISE,  32'h0);
    rd_check("glitch_fall",  SWIN_FALL,  32'h0);

    // Masked rise on sw_in[0]: flag at edge 18, irq at edge 19.
    wr_check("mask_wr", SWIN_MASK, 32'h1);
    rd_check("mask_rd", SWIN_MASK, 32'h1);
    sw_in = 10'h001;
    tick(18);
    check_value("irq_e18", {31'd0, irq}, 32'd0);
    tick(1);
    check_value("irq_e19", {31'd0, irq}, 32'd1);
    rd_check("irq_rise", SWIN_RISE, 32'h1);
    check_value("irq_clr_edge", {31'd0, irq}, 32'd1);
    tick(1);
    check_value("irq_after_clr", {31'd0, irq}, 32'd0);
    wr_check("mask_off", SWIN_MASK, 32'h0);
    sw_in = 10'h000;
    tick(25);
    rd_check("irq_fall", SWIN_FALL, 32'h1);
    check_value("irq_unmasked_fall", {31'd0, irq}, 32'd0);

    // sw_in[5] rise lands on the same edge as a RISE read: set wins.
    sw_in = 10'h020;
    tick(17);
    rd_check("race_rd1", SWIN_RISE, 32'h0);
    rd_check("race_rd2", SWIN_RISE, 32'h20);
    rd_check("race_rd3", SWIN_RISE, 32'h0);

    // Decode misses and unwritable bits.
    rd_check("miss_pre", SWIN_STATE, 32'h20);
    bus_access(1'b0, BASE + 32'h10, 32'h0, d, a);
    check_value("miss_rd_ack", {31'd0, a}, 32'd0);
    check_value("miss_rd_data", d, 32'h20);
    bus_access(1'b1, BASE + 32'h10, 32'h3ff, d, a);
    check_value("miss_wr_ack", {31'd0, a}, 32'd0);
    bus_access(1'b1, BASE - 32'h4, 32'h3ff, d, a);
    check_value("miss_led_ack", {31'd0, a}, 32'd0);
    rd_check("miss_mask", SWIN_MASK, 32'h0);
    wr_check("mask_all", SWIN_MASK, 32'hffff_ffff);
    rd_check("mask_width", SWIN_MASK, 32'h3ff);
    wr_check("state_wr", SWIN_STATE, 32'hffff);
    rd_check("state_ro", SWIN_STATE, 32'h20);
    rd_check("addr_lsb", SWIN_STATE + 32'h3, 32'h20);

    // Reset mid-debounce and mid-access: fresh count completes at edge 29.
    sw_in = 10'h022;
    tick(10);
    reset = 1'b1;
    bus_en = 1'b1; bus_we = 1'b0; bus_adrs = BASE + SWIN_STATE;
    @(posedge clk_cpu);
    #1;
    reset = 1'b0;
    bus_en = 1'b0;
    check_value("rst_mid_ack", {31'd0, bus_ack}, 32'd0);
    check_value("rst_mid_rdata", bus_rdata, 32'h0);
    check_value("rst_mid_irq", {31'd0, irq}, 32'd0);
    tick(17);
    rd_check("rst_rise_e29", SWIN_RISE, 32'h0);
    rd_check("rst_rise_e30", SWIN_RISE, 32'h22);
    rd_check("rst_mask", SWIN_MASK, 32'h0);
    rd_check("rst_state", SWIN_STATE, 32'h22);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
